// File: rtl/grf_pkg.sv
// -----------------------------------------------------------------------------
// grf_pkg
// Definitions shared by the multi-port general register file (grf_mp) and its
// per-read-port forwarding mux (grf_bypass_mux):
//   GP_IDX / SP_IDX          register indices with non-zero reset contents
//   GP_INIT_DEF/SP_INIT_DEF  default reset values for those registers
//   MAX_NW / WIDX_W          widest write-port hit vector the helper accepts
//   win_port()               highest-index set bit of a write-port hit vector
// -----------------------------------------------------------------------------
package grf_pkg;

    localparam int          GP_IDX      = 28;
    localparam int          SP_IDX      = 29;
    localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;

    localparam int MAX_NW = 32;
    localparam int WIDX_W = 5;

    // hit[j] = write port j is enabled and targets the address of interest.
    // The highest-index port wins, so the ascending scan keeps the last match.
    function automatic logic [WIDX_W-1:0] win_port(input logic [MAX_NW-1:0] hit);
        logic [WIDX_W-1:0] idx;
        idx = '0;
        for (int j = 0; j < MAX_NW; j++) begin
            if (hit[j]) idx = WIDX_W'(j);
        end
        return idx;
    endfunction

endpackage

// File: rtl/grf_bypass_mux.sv
// -----------------------------------------------------------------------------
// grf_bypass_mux
// One read port of the register file. Selects between the stored register
// value and same-cycle write data, and produces the port's busy flag.
// Ports:
//   reset_i   register file reset; suppresses forwarding while asserted
//   raddr_i   read address of this port
//   stored_i  stored value of register raddr_i
//   pend_i    stored pending bit of register raddr_i
//   we_i      write enables of all write ports
//   wa_i      write addresses of all write ports (port j at [j*AW +: AW])
//   wd_i      write data of all write ports (port j at [j*DW +: DW])
//   rdata_o   read data
//   rbusy_o   register still waiting for its producer
// -----------------------------------------------------------------------------
module grf_bypass_mux
    import grf_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NW     = 2,
    parameter int BYPASS = 1
) (
    input  logic             reset_i,
    input  logic [AW-1:0]    raddr_i,
    input  logic [DW-1:0]    stored_i,
    input  logic             pend_i,
    input  logic [NW-1:0]    we_i,
    input  logic [NW*AW-1:0] wa_i,
    input  logic [NW*DW-1:0] wd_i,
    output logic [DW-1:0]    rdata_o,
    output logic             rbusy_o
);

    logic [MAX_NW-1:0] hit;
    logic [WIDX_W-1:0] win;
    logic [DW-1:0]     fwd;

    always_comb begin
        hit = '0;
        for (int j = 0; j < NW; j++) begin
            hit[j] = we_i[j] && (wa_i[j*AW +: AW] == raddr_i);
        end
    end

    assign win = win_port(hit);

    always_comb begin
        fwd = '0;
        for (int j = 0; j < NW; j++) begin
            if (WIDX_W'(j) == win) fwd = wd_i[j*DW +: DW];
        end
    end

    always_comb begin
        rdata_o = stored_i;
        rbusy_o = pend_i;
        if (raddr_i == '0) begin
            // Register 0 is hard-wired to zero and never pending.
            rdata_o = '0;
            rbusy_o = 1'b0;
        end else if ((BYPASS != 0) && !reset_i && (|hit)) begin
            // The value lands this cycle, so it is available now.
            rdata_o = fwd;
            rbusy_o = 1'b0;
        end
    end

endmodule

// File: rtl/grf_mp.sv
// -----------------------------------------------------------------------------
// grf_mp
// Multi-port general register file with NR combinational read ports, NW write
// ports, optional write-to-read forwarding and a per-register pending bit
// (scoreboard) for hazard tracking.
// Ports:
//   clk     clock, all state updates on posedge
//   reset   asynchronous active-high reset of data and pending bits
//   ra      read addresses, port i at ra[i*AW +: AW]
//   rd      read data, port i at rd[i*DW +: DW]
//   rbusy   pending bit of the register addressed by each read port
//   we      write enables
//   wa      write addresses, port j at wa[j*AW +: AW]
//   wd      write data, port j at wd[j*DW +: DW]
//   iss_en  mark register iss_a pending (producer issued)
//   iss_a   destination of the issued producer
//   flush   synchronous clear of all pending bits
//   wconf   two or more enabled write ports target the same nonzero address
// -----------------------------------------------------------------------------
module grf_mp
    import grf_pkg::*;
#(
    parameter int             DW      = 32,
    parameter int             AW      = 5,
    parameter int             NR      = 2,
    parameter int             NW      = 2,
    parameter int             BYPASS  = 1,
    parameter logic [DW-1:0]  GP_INIT = DW'(GP_INIT_DEF),
    parameter logic [DW-1:0]  SP_INIT = DW'(SP_INIT_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    output logic [NR-1:0]    rbusy,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] wa,
    input  logic [NW*DW-1:0] wd,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_a,
    input  logic             flush,
    output logic             wconf
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0]     mem_q  [DEPTH];
    logic [DW-1:0]     mem_d  [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [MAX_NW-1:0] whit   [DEPTH];
    logic [DEPTH-1:0]  multi;

    // GP/SP get their initial values only if the file is deep enough to
    // hold both of them.
    function automatic logic [DW-1:0] rst_val(input int r);
        if ((DEPTH > SP_IDX) && (r == GP_IDX)) return GP_INIT;
        if ((DEPTH > SP_IDX) && (r == SP_IDX)) return SP_INIT;
        return '0;
    endfunction

    // Per-register write-port hit vectors; shared by the update logic and
    // the conflict detector.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            whit[r] = '0;
            for (int j = 0; j < NW; j++) begin
                whit[r][j] = we[j] && (wa[j*AW +: AW] == AW'(r));
            end
            multi[r] = (r != 0) && ($countones(whit[r]) > 1);
        end
    end

    assign wconf = |multi;

    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            mem_d[r]  = mem_q[r];
            pend_d[r] = pend_q[r];
            if ((r != 0) && (|whit[r])) begin
                for (int j = 0; j < NW; j++) begin
                    if (WIDX_W'(j) == win_port(whit[r])) mem_d[r] = wd[j*DW +: DW];
                end
                pend_d[r] = 1'b0;
            end
            // Evaluated after the write clear: a new producer supersedes the
            // completing one, and flush overrides both.
            if (flush) begin
                pend_d[r] = 1'b0;
            end else if (iss_en && (r != 0) && (iss_a == AW'(r))) begin
                pend_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= rst_val(r);
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] raddr;
        assign raddr = ra[i*AW +: AW];

        grf_bypass_mux #(
            .DW     (DW),
            .AW     (AW),
            .NW     (NW),
            .BYPASS (BYPASS)
        ) u_mux (
            .reset_i  (reset),
            .raddr_i  (raddr),
            .stored_i (mem_q[raddr]),
            .pend_i   (pend_q[raddr]),
            .we_i     (we),
            .wa_i     (wa),
            .wd_i     (wd),
            .rdata_o  (rd[i*DW +: DW]),
            .rbusy_o  (rbusy[i])
        );
    end

endmodule

// File: tb/tb_grf_mp.sv
module tb_grf_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 32;

    logic             clk    = 1'b0;
    logic             reset  = 1'b0;
    logic [NR*AW-1:0] ra     = '0;
    logic [NW-1:0]    we     = '0;
    logic [NW*AW-1:0] wa     = '0;
    logic [NW*DW-1:0] wd     = '0;
    logic             iss_en = 1'b0;
    logic [AW-1:0]    iss_a  = '0;
    logic             flush  = 1'b0;

    logic [NR*DW-1:0] rd_b,    rd_n;
    logic [NR-1:0]    rbusy_b, rbusy_n;
    logic             wconf_b, wconf_n;

    int nvec  = 0;
    int nfail = 0;

    logic [31:0] m_mem  [DEPTH];
    bit          m_pend [DEPTH];

    always #5 clk = ~clk;

    grf_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
        .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_a(iss_a),
        .flush(flush), .wconf(wconf_b)
    );

    grf_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
        .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_a(iss_a),
        .flush(flush), .wconf(wconf_n)
    );

    // ---------------- reference model ----------------
    function automatic void m_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r]  = 32'h0;
            m_pend[r] = 1'b0;
        end
        m_mem[28] = 32'h0000_1800;
        m_mem[29] = 32'h0000_2ffc;
    endfunction

    // Apply one clock edge: writes in port order (later port overwrites),
    // then scoreboard issue/flush.
    function automatic void m_edge();
        logic [4:0] a;
        if (reset) begin
            m_reset();
            return;
        end
        for (int j = 0; j < NW; j++) begin
            a = wa[j*AW +: AW];
            if (we[j] && a != 5'd0) begin
                m_mem[a]  = wd[j*DW +: DW];
                m_pend[a] = 1'b0;
            end
        end
        if (flush) begin
            for (int r = 0; r < DEPTH; r++) m_pend[r] = 1'b0;
        end else if (iss_en && iss_a != 5'd0) begin
            m_pend[iss_a] = 1'b1;
        end
    endfunction

    function automatic bit m_written(input logic [4:0] a);
        for (int j = 0; j < NW; j++) begin
            if (we[j] && wa[j*AW +: AW] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] e_rd(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (a == 5'd0) return 32'h0;
        v = m_mem[a];
        if (byp && !reset) begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wa[j*AW +: AW] == a) v = wd[j*DW +: DW];
            end
        end
        return v;
    endfunction

    function automatic logic e_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && !reset && m_written(a)) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic e_wconf();
        for (int j = 0; j < NW; j++) begin
            for (int k = j + 1; k < NW; k++) begin
                if (we[j] && we[k] && wa[j*AW +: AW] == wa[k*AW +: AW] && wa[j*AW +: AW] != 5'd0)
                    return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [4:0] a;
        for (int p = 0; p < NR; p++) begin
            a = ra[p*AW +: AW];
            chk($sformatf("%s.rd%0d(r%0d)", tag, p, a),        rd_b[p*DW +: DW], e_rd(a, 1'b1));
            chk($sformatf("%s.rbusy%0d(r%0d)", tag, p, a),     32'(rbusy_b[p]),  32'(e_busy(a, 1'b1)));
            chk($sformatf("%s.nb_rd%0d(r%0d)", tag, p, a),     rd_n[p*DW +: DW], e_rd(a, 1'b0));
            chk($sformatf("%s.nb_rbusy%0d(r%0d)", tag, p, a),  32'(rbusy_n[p]),  32'(e_busy(a, 1'b0)));
        end
        chk({tag, ".wconf"},    32'(wconf_b), 32'(e_wconf()));
        chk({tag, ".nb_wconf"}, 32'(wconf_n), 32'(e_wconf()));
    endtask

    task automatic drive(input logic [1:0] we_v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic ie, input logic [4:0] ia, input logic fl,
                         input logic [4:0] r0, input logic [4:0] r1);
        we     = we_v;
        wa     = {a1, a0};
        wd     = {d1, d0};
        iss_en = ie;
        iss_a  = ia;
        flush  = fl;
        ra     = {r1, r0};
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, r0, r1);
    endtask

    // Check combinational outputs mid-cycle, then take one edge.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle(5'd28, 5'd29);
        m_reset();

        // Asynchronous reset between edges, visible before any clock.
        #2 reset = 1'b1;
        #1 check_all("rst_async");
        ra = {5'd0, 5'd5};
        #1 check_all("rst_r5");
        @(posedge clk);
        m_edge();
        #1 reset = 1'b0;

        // Write then read (same-cycle bypass vs. stored-only build).
        drive(2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
        cycle("wr3");
        idle(5'd3, 5'd28);
        cycle("rd3");

        // Write conflict, then same pattern on register 0.
        drive(2'b11, 5'd7, 5'd7, 32'h1111, 32'h2222, 1'b0, 5'd0, 1'b0, 5'd7, 5'd3);
        cycle("conf7");
        idle(5'd7, 5'd7);
        cycle("rd7");
        drive(2'b11, 5'd0, 5'd0, 32'h1111, 32'h2222, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
        cycle("conf0");

        // Scoreboard sequence on register 9.
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
        cycle("iss9");
        idle(5'd9, 5'd9);
        cycle("busy9");
        drive(2'b10, 5'd0, 5'd9, 32'h0, 32'h9999, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
        cycle("wr9");
        idle(5'd9, 5'd9);
        cycle("free9");
        drive(2'b01, 5'd9, 5'd0, 32'hA9A9, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd1);
        cycle("iss_wr9");
        idle(5'd9, 5'd9);
        cycle("still9");
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, 5'd9);
        cycle("flush9");
        idle(5'd9, 5'd9);
        cycle("flushed9");

        // Register 0 ignores writes and issues.
        drive(2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        cycle("r0_wr");
        idle(5'd0, 5'd0);
        cycle("r0_rd");

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            logic [4:0]  a0, a1, r0, r1, ia;
            logic [1:0]  wv;
            logic        ie, fl;
            a0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wv = 2'($urandom);
            ie = ($urandom_range(0, 2) == 0);
            ia = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            fl = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       r0 = a0;
                1:       r0 = a1;
                default: r0 = 5'($urandom);
            endcase
            r1 = ($urandom_range(0, 1) != 0) ? a1 : 5'($urandom_range(0, 3));
            drive(wv, a0, a1, $urandom, $urandom, ie, ia, fl, r0, r1);
            cycle($sformatf("rnd%0d", k));
        end

        // Reset in the middle of operation, coincident with a write.
        drive(2'b01, 5'd4, 5'd0, 32'h55, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd29);
        cycle("r4_set");
        idle(5'd4, 5'd29);
        cycle("r4_busy");
        drive(2'b01, 5'd4, 5'd0, 32'hAA, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd29);
        #3 reset = 1'b1;
        m_reset();
        #1 check_all("rst_mid_async");
        @(posedge clk);
        m_edge();
        #1 reset = 1'b0;
        idle(5'd4, 5'd29);
        cycle("rst_mid_after");
        idle(5'd28, 5'd5);
        cycle("rst_mid_gp");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised multi-port general register file.
- Generalises the single-write, two-read GRF to NR read ports and NW write ports, with configurable data width and depth.
- Adds an optional write-to-read bypass and per-register pending (scoreboard) bits for hazard tracking in the pipelined and superscalar cores.
- Sits in the decode stage: read ports feed operand muxes, write ports come from writeback, and the issue port comes from decode.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW.
- NR, 2, number of read ports (>=1).
- NW, 2, number of write ports (>=1).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.
- GP_INIT, 32'h0000_1800, reset value of register 28.
- SP_INIT, 32'h0000_2ffc, reset value of register 29.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears state immediately on assertion.
- ra  in  NR*AW  read addresses; port i uses ra[i*AW +: AW].
- rd  out  NR*DW  read data; port i uses rd[i*DW +: DW].
- rbusy  out  NR  pending bit of the register addressed by each read port.
- we  in  NW  write enables.
- wa  in  NW*AW  write addresses.
- wd  in  NW*DW  write data.
- iss_en  in  1  mark register iss_a pending (producer issued).
- iss_a  in  AW  destination of the issued producer.
- flush  in  1  synchronous clear of all pending bits.
- wconf  out  1  combinational; two or more enabled write ports target the same nonzero address this cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - All registers become 0, except reg 28 = GP_INIT and reg 29 = SP_INIT.
  - GP_INIT/SP_INIT are applied only when depth > 29; otherwise those registers are plain 0.
  - All pending bits become 0.
  - Outputs during reset: rd follows the reset contents; rbusy = 0.
  - Reset asserted mid-cycle overrides any same-edge write or issue.
- Register 0:
  - Reads always return 0.
  - Writes to it are ignored.
  - Its pending bit is never set (iss_en with iss_a = 0 is ignored).
  - It is excluded from wconf.
- Writes:
  - Take effect on posedge clk when we[j]=1 and wa[j] != 0.
  - Several enabled ports to the same address: the highest-index port wins; wconf = 1 for that cycle.
  - Lower-index writes to other addresses still complete.
- Reads are combinational, with zero-cycle latency from ra.
  - BYPASS=1, and an enabled write this cycle targets ra[i] != 0: rd[i] = wd of the winning (highest-index) port.
  - Otherwise rd[i] = the stored value.
  - BYPASS=0: rd[i] = stored value; new data is visible the cycle after the write edge.
- Pending bits, updated per register on posedge:
  - Set when iss_en and iss_a == r.
  - Cleared when any enabled write targets r.
  - Set and clear in the same cycle on the same register: set wins (the new producer supersedes the completing one).
  - flush = 1 clears all bits and takes priority over iss_en in the same cycle.
  - Writes during flush still update data.
- rbusy[i]:
  - Equals the stored pending bit of ra[i].
  - With BYPASS=1 it is forced to 0 when a same-cycle write to ra[i] is bypassed (the value is available).
  - Always 0 for ra[i] = 0.
- No internal state machine beyond the storage and pending arrays.
- Every write edge produces a result visible within one cycle; there is no stall or backpressure.

Decomposition:
- Shared package grf_pkg holds:
  - GP_IDX = 28, SP_IDX = 29.
  - Default GP_INIT and SP_INIT.
  - A function returning the winning write port for a given address (priority encode, highest index first).
- One natural sub-module: grf_bypass_mux.
  - Per-read-port instance.
  - Inputs: stored value, pending bit, and the write-port vectors.
  - Outputs: rd[i] and rbusy[i].
  - Instantiated NR times via generate.

Test Plan:
- Reset values: assert reset asynchronously between edges -> immediately rd for ra=28 is 32'h00001800, ra=29 is 32'h00002ffc, ra=5 is 0; all rbusy = 0.
- Write then read: we[0]=1, wa=3, wd=32'hDEADBEEF.
  - Same cycle, BYPASS=1 -> rd(ra=3) = DEADBEEF.
  - Next cycle, we=0 -> still DEADBEEF.
  - BYPASS=0 build -> old value 0 in the write cycle.
- Write conflict: we=2'b11, wa[0]=wa[1]=7, wd0=32'h1111, wd1=32'h2222 -> wconf=1 and reg 7 = 32'h2222 after the edge. Repeat with address 0 -> wconf=0 and reg 0 reads 0.
- Scoreboard sequence on reg 9:
  - iss_en, iss_a=9 -> rbusy(9)=1 next cycle.
  - Write to 9 -> bypass-cycle rbusy=0, then stored 0.
  - Simultaneous iss_en=9 and write to 9 -> pending stays 1.
  - flush together with iss_en=9 -> pending 0.
- Register 0: we=1, wa=0, wd=32'hFFFFFFFF, plus iss_en, iss_a=0 -> rd(0)=0 and rbusy=0 on every port.
- Reset mid-operation: reg 4 = 32'h55, reg 4 pending; assert reset coincident with a write of 32'hAA to reg 4 -> reg 4 = 0 and pending = 0 after release; reg 29 = 32'h00002ffc.
